// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline sequencer for the 5-stage core. Merges per-stage
//               stall requests into the shared stall vector, sequences
//               MEM-stage exception flushes, counts stalled cycles and runs
//               a sticky stall watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_if,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic             excp_valid,
    input  logic [31:0]      excp_vector,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             stall_timeout
);

    localparam logic [1:0]  c_RUN      = 2'd0;
    localparam logic [1:0]  c_EXC_WAIT = 2'd1;
    localparam logic [1:0]  c_FLUSH    = 2'd2;

    // Acceptance freezes IF..MEM and bubbles MEM/WB so the faulting
    // instruction never reaches writeback.
    localparam logic [5:0]  c_ACCEPT_STALL = 6'b011111;
    localparam logic [31:0] c_TIMEOUT      = 32'(TIMEOUT);
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [31:0]      r_pending;
    logic [31:0]      r_new_pc;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [15:0]      r_consec;
    logic             r_timeout;

    logic [5:0]       w_enc;
    logic [5:0]       w_stall;
    logic             w_flush;
    logic             w_accept;
    logic             w_defer;
    logic [31:0]      w_accept_pc;
    logic [15:0]      w_consec_nxt;
    logic             w_timeout_hit;

    // Priority encoder: the oldest stalled stage dictates how far back the freeze reaches.
    always_comb begin
        w_enc = 6'b000000;
        if (stallreq_mem)     w_enc = 6'b011111;
        else if (stallreq_ex) w_enc = 6'b001111;
        else if (stallreq_id) w_enc = 6'b000111;
        else if (stallreq_if) w_enc = 6'b000011;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_RUN;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic: exceptions wait for the data bus, then flush for one cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_RUN: begin
                if (w_accept)     w_state_nxt = c_FLUSH;
                else if (w_defer) w_state_nxt = c_EXC_WAIT;
            end
            c_EXC_WAIT: begin
                if (w_accept) w_state_nxt = c_FLUSH;
            end
            c_FLUSH:  w_state_nxt = c_RUN;
            default:  w_state_nxt = c_RUN;
        endcase
    end

    // Output logic: stall vector, flush pulse and exception handshake strobes.
    always_comb begin
        w_stall  = 6'b000000;
        w_flush  = 1'b0;
        w_accept = 1'b0;
        w_defer  = 1'b0;
        if (!rst) begin
            case (r_state)
                c_RUN: begin
                    w_stall = w_enc;
                    if (excp_valid) begin
                        if (!stallreq_mem) begin
                            w_accept = 1'b1;
                            w_stall  = c_ACCEPT_STALL;
                        end else begin
                            w_defer = 1'b1;
                        end
                    end
                end
                c_EXC_WAIT: begin
                    // New exceptions are ignored here; the first vector is kept.
                    w_stall = w_enc;
                    if (!stallreq_mem) begin
                        w_accept = 1'b1;
                        w_stall  = c_ACCEPT_STALL;
                    end
                end
                c_FLUSH:  w_flush = 1'b1;
                default:  w_flush = 1'b0;
            endcase
        end
    end

    assign w_accept_pc   = (r_state == c_EXC_WAIT) ? r_pending : excp_vector;
    assign w_consec_nxt  = (w_stall == 6'b000000) ? 16'd0 :
                           (r_consec == 16'hFFFF) ? r_consec : r_consec + 16'd1;
    assign w_timeout_hit = ({16'd0, w_consec_nxt} >= c_TIMEOUT);

    // Datapath: exception vectors, stall statistics and watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending      <= 32'd0;
            r_new_pc       <= 32'd0;
            r_stall_cycles <= '0;
            r_consec       <= 16'd0;
            r_timeout      <= 1'b0;
        end else begin
            if (w_defer)  r_pending <= excp_vector;
            if (w_accept) r_new_pc  <= w_accept_pc;
            if (w_stall != 6'b000000) r_stall_cycles <= r_stall_cycles + c_CNT_ONE;
            r_consec <= w_consec_nxt;
            if (w_timeout_hit) r_timeout <= 1'b1;
        end
    end

    assign stall         = w_stall;
    assign flush         = w_flush;
    assign new_pc        = r_new_pc;
    assign stall_cycles  = r_stall_cycles;
    assign stall_timeout = r_timeout;

endmodule
`default_nettype wire
